// File: rtl/mem_arbiter.sv
// Two-requester (IF / LS) arbiter for a single-ported byte-addressed RAM with one-cycle read return.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate owners on contention instead of fixed LS priority.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic [2:0]        ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic [2:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt == LIMIT) ? cnt : cnt + 4'd1;
  endfunction

  owner_t              r_owner, w_owner_nxt;
  logic [3:0]          r_wait_cnt, w_wait_nxt;
  logic [ADDR_W-1:0]   r_addr_last;
  logic                r_if_vld_p1, r_ls_vld_p1;
  logic [31:0]         r_if_rdata_p1, r_ls_rdata_p1;
  logic                w_starved, w_if_on_tie, w_if_win, w_ls_win;

  // Stage 0: grant selection and RAM issue
  always_comb begin
    w_starved = (r_wait_cnt == LIMIT);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_if_on_tie = w_starved | (r_owner == OWN_LS);
`else
    w_if_on_tie = w_starved;
`endif
    w_if_win = rst_n & if_req & (~ls_req | w_if_on_tie);
    w_ls_win = rst_n & ls_req & ~w_if_win;
  end

  always_comb begin
    mem_we    = 3'b000;
    mem_wdata = 32'd0;
    mem_addr  = r_addr_last;
    if (w_ls_win) begin
      mem_we    = ls_we;
      mem_wdata = ls_wdata;
      mem_addr  = ls_addr;
    end else if (w_if_win) begin
      mem_addr  = if_addr;
    end
  end

  always_comb begin
    w_owner_nxt = r_owner;
    if (w_ls_win)      w_owner_nxt = OWN_LS;
    else if (w_if_win) w_owner_nxt = OWN_IF;
    w_wait_nxt = (if_req && !w_if_win) ? sat_inc(r_wait_cnt) : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_wait_cnt  <= 4'd0;
      r_addr_last <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_if_win || w_ls_win) r_addr_last <= mem_addr;
    end
  end

  // Stage 1: registered response; write acks return zero data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_vld_p1   <= 1'b0;
      r_ls_vld_p1   <= 1'b0;
      r_if_rdata_p1 <= 32'd0;
      r_ls_rdata_p1 <= 32'd0;
    end else begin
      r_if_vld_p1 <= w_if_win;
      r_ls_vld_p1 <= w_ls_win;
      if (w_if_win) r_if_rdata_p1 <= mem_rdata;
      if (w_ls_win) r_ls_rdata_p1 <= (ls_we == 3'b000) ? mem_rdata : 32'd0;
    end
  end

  assign if_gnt    = w_if_win;
  assign ls_gnt    = w_ls_win;
  assign if_rvalid = r_if_vld_p1;
  assign ls_rvalid = r_ls_vld_p1;
  assign if_rdata  = r_if_rdata_p1;
  assign ls_rdata  = r_ls_rdata_p1;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported byte-addressed data RAM between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the core and the RAM.
- Issues at most one access per cycle and returns read data one cycle later.
- Prevents IF starvation with a wait counter.

Parameters:
- ADDR_W, 32, address width of all ports.
- STARVE_LIMIT, 4, consecutive cycles IF may be denied while requesting before IF is forced to win; legal range 1..15.

Ports:
- clk  input  1  clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- if_req  input  1  IF request; held with if_addr until granted.
- if_addr  input  ADDR_W  IF byte address.
- if_gnt  output  1  IF access issued this cycle (combinational).
- if_rvalid  output  1  IF read data valid (registered).
- if_rdata  output  32  IF read data.
- ls_req  input  1  LS request; held with ls_we, ls_addr and ls_wdata until granted.
- ls_we  input  3  one-hot write size: [0] word, [1] halfword, [2] byte; 0 means read.
- ls_addr  input  ADDR_W  LS byte address.
- ls_wdata  input  32  LS write data, right-justified.
- ls_gnt  output  1  LS access issued this cycle (combinational).
- ls_rvalid  output  1  LS response (read data or write ack) valid (registered).
- ls_rdata  output  32  LS read data; 0 for write acks.
- mem_we  output  3  to RAM write_enable.
- mem_addr  output  ADDR_W  to RAM addr.
- mem_wdata  output  32  to RAM data_in.
- mem_rdata  input  32  from RAM data_out; combinational, big-endian word at mem_addr.

Behaviour:
- Reset (async, rst_n=0): if_rvalid=0, ls_rvalid=0, if_rdata=0, ls_rdata=0, wait_cnt=0, last_owner=IF.
- Combinational outputs during reset: mem_we=0; if_gnt and ls_gnt forced to 0.
- Grant selection, per cycle, combinational:
  - Only one requester active: it wins.
  - Both active and wait_cnt==STARVE_LIMIT: IF wins.
  - Both active otherwise: LS wins (fixed priority, see optional feature).
  - Neither active: no grant; mem_we=0, mem_addr holds its last value.
- Issue: the winner's address drives mem_addr.
  - LS winner: mem_we=ls_we, mem_wdata=ls_wdata.
  - IF winner: mem_we=0, mem_wdata=0.
- ls_we with more than one bit set: treated as word write (bit0 priority), matching RAM priority.
- Latency: if granted in cycle N, {x}_rvalid is asserted for exactly one cycle in N+1, and {x}_rdata = mem_rdata sampled at the end of cycle N.
- LS write: ls_rvalid pulses in N+1 with ls_rdata=0; the RAM commits the write at the same edge.
- rvalid deasserts the cycle after the pulse unless a new grant was issued. Back-to-back grants to one requester give continuous rvalid.
- rdata registers hold their value when rvalid=0.
- wait_cnt (4 bits):
  - Increments when if_req=1 and if_gnt=0, saturating at STARVE_LIMIT.
  - Clears when if_gnt=1 or if_req=0.
- last_owner updates to the winner on every grant.
- A requester must not drop req before its grant; behaviour if it does is undefined.
- Dropping req in the same cycle as the grant is allowed.
- Reset asserted mid-access: pending rvalid is lost (0 after reset); the RAM write at that edge is not guaranteed.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a both-request cycle with wait_cnt<STARVE_LIMIT, the requester that is not last_owner wins (strict alternation).
- Undefined: LS has fixed priority; the starvation counter alone guarantees IF progress.
- The wait_cnt rule applies in both builds.

Test Plan:
- Reset with if_req=1, ls_req=1: all rvalid=0, if_gnt=ls_gnt=0, mem_we=0 while rst_n=0. After release, cycle 1 grants LS (ls_gnt=1); RR build grants LS because last_owner=IF.
- IF alone: if_addr=0, RAM preloaded 0x0001F0B7 at bytes 0..3 -> if_gnt=1, next cycle if_rvalid=1, if_rdata=0x0001F0B7, ls_rvalid=0.
- LS byte write: ls_we=3'b100, ls_addr=5, ls_wdata=0xAB -> mem_we=3'b100, next cycle ls_rvalid=1, ls_rdata=0. LS word read of addr 4 then returns 0x00AB0000.
- Starvation: both requests held continuously, STARVE_LIMIT=4, fixed-priority build -> LS granted 4 cycles, IF granted on 5th cycle, wait_cnt returns to 0, then LS again.
- RR build, both requesting 6 cycles -> grants alternate LS, IF, LS, IF, LS, IF; the rvalids alternate one cycle later.
- Halfword write ls_we=3'b010, ls_addr=8, ls_wdata=0x1234 issued while if_req=0 -> word read at 8 yields 0x12340000; async reset pulse mid-sequence clears ls_rvalid immediately.
